oam_dma_arbiter: RTL and testbench

//  Owns the shared memory bus between the CPU core and the OAM DMA engine. Decodes DMA register

---
 rtl/oam_dma_arbiter.sv | 164 ++++++++++++++++
 tb/tb_oam_dma_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter.sv
// Shared memory bus arbiter between the CPU core and the OAM DMA engine.
// Optional `DMA_DONE_PULSE_EN adds a one-cycle o_DMA_Done completion pulse.
module oam_dma_arbiter #(
    parameter int unsigned DMA_LENGTH   = 160,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] DEST_BASE    = 16'hFE00,
    parameter int unsigned START_DELAY  = 1,
    parameter logic [7:0]  BLOCK_FILL   = 8'hFF
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Enable,
    input  logic [15:0] i_CPU_Address,
    input  logic [7:0]  i_CPU_Data,
    input  logic        i_CPU_Write,
    input  logic        i_CPU_Read,
    output logic [7:0]  o_CPU_Data,
    output logic [15:0] o_Mem_Address,
    output logic [7:0]  o_Mem_Data,
    output logic        o_Mem_Write,
    output logic        o_Mem_Read,
    input  logic [7:0]  i_Mem_Data,
`ifdef DMA_DONE_PULSE_EN
    output logic        o_DMA_Done,
`endif
    output logic        o_DMA_Active
);

    typedef enum logic [1:0] {IDLE, DELAY, READ, WRITE} state_t;

    localparam logic [7:0] LAST_IDX   = 8'(DMA_LENGTH - 1);
    localparam logic [3:0] DELAY_INIT = 4'(START_DELAY);

    state_t     state, state_next;
    logic [7:0] idx, idx_next;
    logic [7:0] page, page_next;
    logic [7:0] latch, latch_next;
    logic [3:0] cnt, cnt_next;

    logic        cpu_wr, cpu_rd, cpu_strobe, reg_hit, cpu_high, cpu_owns, trigger;
    logic [15:0] src_addr, dst_addr;

    assign cpu_wr     = i_CPU_Write;
    assign cpu_rd     = i_CPU_Read & ~i_CPU_Write;
    assign cpu_strobe = i_CPU_Write | i_CPU_Read;
    assign reg_hit    = (i_CPU_Address == DMA_REG_ADDR);
    assign cpu_high   = (i_CPU_Address >= 16'hFF00);
    assign cpu_owns   = cpu_strobe & (~o_DMA_Active | cpu_high);
    assign trigger    = cpu_wr & reg_hit;
    assign src_addr   = {page, 8'h00} + {8'h00, idx};
    assign dst_addr   = DEST_BASE + {8'h00, idx};

    // Bus mux: CPU owns the bus when idle or for high-page accesses; otherwise DMA drives it.
    always_comb begin
        o_Mem_Address = '0;
        o_Mem_Data    = '0;
        o_Mem_Write   = 1'b0;
        o_Mem_Read    = 1'b0;
        o_CPU_Data    = i_Mem_Data;
        if (cpu_owns) begin
            if (reg_hit) begin
                o_CPU_Data = page;
            end else begin
                o_Mem_Address = i_CPU_Address;
                o_Mem_Write   = cpu_wr;
                o_Mem_Read    = cpu_rd;
                o_Mem_Data    = cpu_wr ? i_CPU_Data : '0;
            end
        end else begin
            if (o_DMA_Active) o_CPU_Data = BLOCK_FILL;
            case (state)
                READ: begin
                    o_Mem_Address = src_addr;
                    o_Mem_Read    = 1'b1;
                end
                WRITE: begin
                    o_Mem_Address = dst_addr;
                    o_Mem_Data    = latch;
                    o_Mem_Write   = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DMA_DONE_PULSE_EN
    logic done_set;
`endif

    always_comb begin
        state_next = state;
        idx_next   = idx;
        page_next  = page;
        latch_next = latch;
        cnt_next   = cnt;
`ifdef DMA_DONE_PULSE_EN
        done_set   = 1'b0;
`endif
        // A register write restarts the copy from any state, discarding the byte in flight.
        if (trigger) begin
            page_next  = i_CPU_Data;
            idx_next   = '0;
            cnt_next   = DELAY_INIT;
            state_next = (START_DELAY == 0) ? READ : DELAY;
        end else begin
            case (state)
                DELAY: begin
                    if (cnt <= 4'd1) begin
                        cnt_next   = '0;
                        state_next = READ;
                    end else begin
                        cnt_next = cnt - 4'd1;
                    end
                end
                READ: begin
                    if (!cpu_owns) begin
                        latch_next = i_Mem_Data;
                        state_next = WRITE;
                    end
                end
                WRITE: begin
                    if (!cpu_owns) begin
                        if (idx == LAST_IDX) begin
                            idx_next   = '0;
                            state_next = IDLE;
`ifdef DMA_DONE_PULSE_EN
                            done_set   = 1'b1;
`endif
                        end else begin
                            idx_next   = idx + 8'd1;
                            state_next = READ;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state        <= IDLE;
            idx          <= '0;
            page         <= '0;
            latch        <= '0;
            cnt          <= '0;
            o_DMA_Active <= 1'b0;
`ifdef DMA_DONE_PULSE_EN
            o_DMA_Done   <= 1'b0;
`endif
        end else if (i_Enable) begin
            state        <= state_next;
            idx          <= idx_next;
            page         <= page_next;
            latch        <= latch_next;
            cnt          <= cnt_next;
            o_DMA_Active <= (state_next != IDLE);
`ifdef DMA_DONE_PULSE_EN
            o_DMA_Done   <= done_set;
`endif
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed self-checking bench for oam_dma_arbiter with a 64 KiB behavioural memory.
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wr, cpu_rd;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_wr, mem_rd, dma_active;
`ifdef DMA_DONE_PULSE_EN
    logic        dma_done;
`endif

    logic [7:0] mem [0:65535];
    assign mem_rdata = mem[mem_addr];

    int checks = 0;
    int passes = 0;
    int act_cycles = 0;
    int done_cnt = 0;
    int errs;

    always #5 clk = ~clk;

    oam_dma_arbiter #(
        .DMA_LENGTH(160), .DMA_REG_ADDR(16'hFF46), .DEST_BASE(16'hFE00),
        .START_DELAY(1), .BLOCK_FILL(8'hFF)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
        .i_CPU_Address(cpu_addr), .i_CPU_Data(cpu_wdata),
        .i_CPU_Write(cpu_wr), .i_CPU_Read(cpu_rd), .o_CPU_Data(cpu_rdata),
        .o_Mem_Address(mem_addr), .o_Mem_Data(mem_wdata),
        .o_Mem_Write(mem_wr), .o_Mem_Read(mem_rd), .i_Mem_Data(mem_rdata),
`ifdef DMA_DONE_PULSE_EN
        .o_DMA_Done(dma_done),
`endif
        .o_DMA_Active(dma_active)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Samples in the low phase, commits memory writes, then advances one clock.
    task automatic tick();
        if (en && dma_active) act_cycles++;
`ifdef DMA_DONE_PULSE_EN
        if (en && dma_done) done_cnt++;
`endif
        if (mem_wr) mem[mem_addr] = mem_wdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cpu(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
        cpu_addr = a; cpu_wdata = d; cpu_wr = w; cpu_rd = r;
        #1;
    endtask

    task automatic trigger(input logic [7:0] pg);
        cpu(16'hFF46, pg, 1'b1, 1'b0);
        check("trig_no_wr", {15'd0, mem_wr}, 16'd0);
        check("trig_no_rd", {15'd0, mem_rd}, 16'd0);
        tick();
        cpu(16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && dma_active; i++) tick();
        check("dma_timeout", {15'd0, dma_active}, 16'd0);
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = 8'h00;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
            mem[16'hD000 + 16'(i)] = 8'(i) + 8'h30;
        end
        mem[16'hC000] = 8'h3C;
        mem[16'hFF80] = 8'h77;
        rst = 1'b1; en = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        ticks(2);
        rst = 1'b0;
        #1;

        // Reset state and idle pass-through
        check("rst_active", {15'd0, dma_active}, 16'd0);
        check("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
        check("rst_mem_wr", {15'd0, mem_wr}, 16'd0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_data", {8'd0, mem_wdata}, 16'h0000);
        cpu(16'hC000, 8'h00, 1'b0, 1'b1);
        check("idle_rd_strobe", {15'd0, mem_rd}, 16'd1);
        check("idle_rd_addr", mem_addr, 16'hC000);
        check("idle_rd_data", {8'd0, cpu_rdata}, 16'h003C);
        check("idle_rd_active", {15'd0, dma_active}, 16'd0);
        cpu(16'hC200, 8'hAB, 1'b1, 1'b1);
        check("both_wr", {15'd0, mem_wr}, 16'd1);
        check("both_no_rd", {15'd0, mem_rd}, 16'd0);
        check("both_data", {8'd0, mem_wdata}, 16'h00AB);
        tick();
        check("both_mem", {8'd0, mem[16'hC200]}, 16'h00AB);
        cpu(16'h0000, 8'h00, 1'b0, 1'b0);

        // Full transfer from page C1
        act_cycles = 0; done_cnt = 0;
        trigger(8'hC1);
        check("t2_active_rise", {15'd0, dma_active}, 16'd1);
        check("t2_delay_no_rd", {15'd0, mem_rd}, 16'd0);
        tick();
        check("t2_first_addr", mem_addr, 16'hC100);
        check("t2_first_rd", {15'd0, mem_rd}, 16'd1);
        wait_idle();
        check("t2_active_cycles", 16'(act_cycles), 16'd321);
        errs = 0;
        for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) errs++;
        check("t2_oam_errs", 16'(errs), 16'd0);
`ifdef DMA_DONE_PULSE_EN
        check("t2_done_pulses", 16'(done_cnt), 16'd1);
`endif
        cpu(16'hFF46, 8'h00, 1'b0, 1'b1);
        check("t2_reg_read", {8'd0, cpu_rdata}, 16'h00C1);
        check("t2_reg_no_rd", {15'd0, mem_rd}, 16'd0);
        cpu(16'h0000, 8'h00, 1'b0, 1'b0);

        // Blocked low accesses, then high-page stall
        clear_oam();
        act_cycles = 0; done_cnt = 0;
        trigger(8'hC1);
        ticks(5);
        cpu(16'h8000, 8'h00, 1'b0, 1'b1);
        check("t3_block_data", {8'd0, cpu_rdata}, 16'h00FF);
        check("t3_dma_rd_addr", mem_addr, 16'hC102);
        check("t3_dma_rd", {15'd0, mem_rd}, 16'd1);
        tick();
        cpu(16'hC000, 8'h12, 1'b1, 1'b0);
        check("t3_dma_wr_addr", mem_addr, 16'hFE02);
        check("t3_dma_wr_data", {8'd0, mem_wdata}, 16'h0058);
        check("t3_dma_wr", {15'd0, mem_wr}, 16'd1);
        tick();
        cpu(16'hFF80, 8'h00, 1'b0, 1'b1);
        check("t4_high_addr", mem_addr, 16'hFF80);
        check("t4_high_data", {8'd0, cpu_rdata}, 16'h0077);
        ticks(3);
        cpu(16'h0000, 8'h00, 1'b0, 1'b0);
        check("t4_resume_addr", mem_addr, 16'hC103);
        wait_idle();
        check("t4_active_cycles", 16'(act_cycles), 16'd324);
        check("t3_c000_kept", {8'd0, mem[16'hC000]}, 16'h003C);
        errs = 0;
        for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) errs++;
        check("t4_oam_errs", 16'(errs), 16'd0);

        // Retrigger at idx 50 with page D0
        clear_oam();
        act_cycles = 0; done_cnt = 0;
        trigger(8'hC1);
        ticks(101);
        check("t5_idx50_addr", mem_addr, 16'hC132);
        trigger(8'hD0);
        check("t5_still_active", {15'd0, dma_active}, 16'd1);
        act_cycles = 0;
        wait_idle();
        check("t5_active_cycles", 16'(act_cycles), 16'd321);
        errs = 0;
        for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== (8'(i) + 8'h30)) errs++;
        check("t5_oam_errs", 16'(errs), 16'd0);
`ifdef DMA_DONE_PULSE_EN
        check("t5_done_pulses", 16'(done_cnt), 16'd1);
`endif
        cpu(16'hFF46, 8'h00, 1'b0, 1'b1);
        check("t5_reg_read", {8'd0, cpu_rdata}, 16'h00D0);
        cpu(16'h0000, 8'h00, 1'b0, 1'b0);

        // Enable freeze, then reset abort
        clear_oam();
        done_cnt = 0;
        trigger(8'hC1);
        ticks(11);
        check("t6_pre_addr", mem_addr, 16'hC105);
        en = 1'b0;
        ticks(10);
        en = 1'b1;
        #1;
        check("t6_frozen_addr", mem_addr, 16'hC105);
        check("t6_frozen_rd", {15'd0, mem_rd}, 16'd1);
        tick();
        check("t6_wr_addr", mem_addr, 16'hFE05);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t6_rst_active", {15'd0, dma_active}, 16'd0);
        check("t6_rst_wr", {15'd0, mem_wr}, 16'd0);
        check("t6_rst_rd", {15'd0, mem_rd}, 16'd0);
        ticks(20);
        check("t6_stays_idle", {15'd0, dma_active}, 16'd0);
        check("t6_oam_fe05", {8'd0, mem[16'hFE05]}, 16'h005F);
        check("t6_oam_fe06", {8'd0, mem[16'hFE06]}, 16'h0000);
`ifdef DMA_DONE_PULSE_EN
        check("t6_no_done", 16'(done_cnt), 16'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
